// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;

    localparam logic [3:0] BCD_NINE = 4'h9;

    // Largest value representable in the given number of decimal digits (10^digits - 1).
    function automatic logic [63:0] pow10_max(input int digits);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < digits; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble correction step: a BCD digit of 5 or more gets +3 before the shift.
module bcd_digit_adj (
    input  logic [3:0] digit,
    output logic [3:0] adj
);

    assign adj = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bcd_convert_seq.sv
// Multi-cycle double-dabble binary-to-BCD converter with valid/ready on both sides.
// Result registers update only when a conversion completes, so the display never sees partial digits.
module bcd_convert_seq
    import bcd_pkg::*;
#(
    parameter int N_BITS = 20,
    parameter int DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_BITS-1:0]     in_bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIGITS*4-1:0]   out_bcd,
    output logic                  out_ovf
);

    localparam int                 CNT_W    = $clog2(N_BITS);
    localparam int                 BCD_W    = DIGITS * 4;
    localparam logic [63:0]        LIMIT    = pow10_max(DIGITS);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(N_BITS - 1);
    localparam logic [BCD_W-1:0]   SAT_BCD  = {DIGITS{BCD_NINE}};

    bcd_state_t          state_reg;
    logic [N_BITS-1:0]   shreg_reg;
    logic [BCD_W-1:0]    work_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic                ovf_flag_reg;

    logic [BCD_W-1:0]    work_adj;
    logic [BCD_W:0]      work_shift;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            bcd_digit_adj u_adj (
                .digit (work_reg[gi*4 +: 4]),
                .adj   (work_adj[gi*4 +: 4])
            );
        end
    endgenerate

    // The bit shifted out of the top digit can only be set for out-of-range inputs,
    // so it simply reinforces saturation.
    assign work_shift = {work_adj, shreg_reg[N_BITS-1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            out_bcd      <= '0;
            out_ovf      <= 1'b0;
            shreg_reg    <= '0;
            work_reg     <= '0;
            cnt_reg      <= '0;
            ovf_flag_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        shreg_reg    <= in_bin;
                        work_reg     <= '0;
                        cnt_reg      <= CNT_LAST;
                        ovf_flag_reg <= (64'(in_bin) > LIMIT);
                        in_ready     <= 1'b0;
                        state_reg    <= SHIFT;
                    end
                end
                SHIFT: begin
                    work_reg  <= work_shift[BCD_W-1:0];
                    shreg_reg <= shreg_reg << 1;
                    cnt_reg   <= cnt_reg - CNT_W'(1);
                    if (cnt_reg == '0) begin
                        state_reg <= DONE;
                        out_valid <= 1'b1;
                        if (ovf_flag_reg || work_shift[BCD_W]) begin
                            out_bcd <= SAT_BCD;
                            out_ovf <= 1'b1;
                        end else begin
                            out_bcd <= work_shift[BCD_W-1:0];
                            out_ovf <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_convert_seq.sv
// Directed-vector bench for bcd_convert_seq: latency, values, overflow, backpressure, reset abort, streaming.
module tb_bcd_convert_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] in_bin;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_bcd;
    logic        out_ovf;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bcd_convert_seq #(.N_BITS(20), .DIGITS(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bin    (in_bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
        .out_ovf   (out_ovf)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present v for one accepting edge, then wait (bounded) for out_valid.
    task automatic convert(input logic [19:0] v, output logic [23:0] bcd, output logic ovf,
                           output int lat, output bit ok);
        in_bin   = v;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 1;
        ok  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            step();
            lat++;
        end
        bcd = out_bcd;
        ovf = out_ovf;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_bin    = '0;
        out_ready = 1'b0;
        step();
        step();
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if (out_bcd !== 24'h000000) begin n_bad++; $display("FAIL reset_out_bcd: got %h expected 000000", out_bcd); end
        n_cmp++; if (out_ovf !== 1'b0) begin n_bad++; $display("FAIL reset_out_ovf: got %b expected 0", out_ovf); end
        reset = 1'b0;
        step();
        $display("reset: in_ready=%b out_valid=%b out_bcd=%h", in_ready, out_valid, out_bcd);
    endtask

    task automatic test_zero();
        logic [23:0] bcd; logic ovf; int lat; bit ok;
        out_ready = 1'b1;
        convert(20'd0, bcd, ovf, lat, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL zero_timeout: got %b expected 1", ok); end
        n_cmp++; if (lat != 21) begin n_bad++; $display("FAIL zero_latency: got %0d expected 21", lat); end
        n_cmp++; if (bcd !== 24'h000000) begin n_bad++; $display("FAIL zero_bcd: got %h expected 000000", bcd); end
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL zero_ovf: got %b expected 0", ovf); end
        $display("zero: in=0 bcd=%h ovf=%b latency=%0d", bcd, ovf, lat);
        step();
    endtask

    task automatic test_values();
        logic [19:0] vin [7] = '{20'd104729, 20'd999999, 20'd1, 20'd9, 20'd10, 20'd99, 20'd500000};
        logic [23:0] vexp[7] = '{24'h104729, 24'h999999, 24'h000001, 24'h000009, 24'h000010, 24'h000099, 24'h500000};
        logic [23:0] bcd; logic ovf; int lat; bit ok;
        out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            convert(vin[k], bcd, ovf, lat, ok);
            n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL value_timeout[%0d]: got %b expected 1", k, ok); end
            n_cmp++; if (bcd !== vexp[k]) begin n_bad++; $display("FAIL value_bcd[%0d]: got %h expected %h", k, bcd, vexp[k]); end
            n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL value_ovf[%0d]: got %b expected 0", k, ovf); end
            $display("value: in=%0d bcd=%h ovf=%b", vin[k], bcd, ovf);
            step();
        end
    endtask

    task automatic test_overflow();
        logic [19:0] vin [2] = '{20'hF4240, 20'hFFFFF};
        logic [23:0] bcd; logic ovf; int lat; bit ok;
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            convert(vin[k], bcd, ovf, lat, ok);
            n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL ovf_timeout[%0d]: got %b expected 1", k, ok); end
            n_cmp++; if (bcd !== 24'h999999) begin n_bad++; $display("FAIL ovf_bcd[%0d]: got %h expected 999999", k, bcd); end
            n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_flag[%0d]: got %b expected 1", k, ovf); end
            $display("overflow: in=%h bcd=%h ovf=%b", vin[k], bcd, ovf);
            step();
        end
    endtask

    task automatic test_backpressure();
        logic [23:0] bcd; logic ovf; int lat; bit ok;
        int errs;
        out_ready = 1'b0;
        convert(20'd31415, bcd, ovf, lat, ok);
        n_cmp++; if (bcd !== 24'h031415) begin n_bad++; $display("FAIL bp_first_bcd: got %h expected 031415", bcd); end
        in_bin   = 20'd42;
        in_valid = 1'b1;
        errs = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold_valid[%0d]: got %b expected 1", i, out_valid); end
            n_cmp++; if (out_bcd !== 24'h031415) begin n_bad++; $display("FAIL bp_hold_bcd[%0d]: got %h expected 031415", i, out_bcd); end
            n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_hold_ready[%0d]: got %b expected 0", i, in_ready); end
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release_valid: got %b expected 0", out_valid); end
        step();
        in_valid = 1'b0;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_accept: got in_ready=%b expected 0", in_ready); end
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) begin ok = 1'b1; break; end
            if (out_bcd !== 24'h031415) errs++;
            step();
        end
        n_cmp++; if (errs != 0) begin n_bad++; $display("FAIL bp_intermediate: got %0d changed cycles expected 0", errs); end
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL bp_second_timeout: got %b expected 1", ok); end
        n_cmp++; if (out_bcd !== 24'h000042) begin n_bad++; $display("FAIL bp_second_bcd: got %h expected 000042", out_bcd); end
        $display("backpressure: held=031415 next=%h", out_bcd);
        out_ready = 1'b1;
        step();
    endtask

    task automatic test_reset_mid_shift();
        logic [23:0] bcd; logic ovf; int lat; bit ok;
        out_ready = 1'b1;
        in_bin    = 20'd777777;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (10) step();
        n_cmp++; if (out_bcd !== 24'h000042) begin n_bad++; $display("FAIL rst_pre_bcd: got %h expected 000042", out_bcd); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if (out_bcd !== 24'h000000) begin n_bad++; $display("FAIL rst_out_bcd: got %h expected 000000", out_bcd); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
        step();
        reset = 1'b0;
        repeat (25) step();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_no_partial: got %b expected 0", out_valid); end
        convert(20'd12345, bcd, ovf, lat, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rst_next_timeout: got %b expected 1", ok); end
        n_cmp++; if (bcd !== 24'h012345) begin n_bad++; $display("FAIL rst_next_bcd: got %h expected 012345", bcd); end
        $display("reset_mid_shift: next in=12345 bcd=%h", bcd);
        step();
    endtask

    task automatic test_back_to_back();
        logic [19:0] vin [4] = '{20'd2, 20'd3, 20'd5, 20'd7};
        logic [23:0] vexp[4] = '{24'h000002, 24'h000003, 24'h000005, 24'h000007};
        int t[4];
        bit ok;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_bin = vin[k];
            ok = 1'b0;
            for (int i = 0; i < 5; i++) begin
                if (in_ready) begin ok = 1'b1; break; end
                step();
            end
            n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_timeout[%0d]: got %b expected 1", k, ok); end
            step();
            ok = 1'b0;
            for (int i = 0; i < 40; i++) begin
                if (out_valid) begin ok = 1'b1; break; end
                step();
            end
            t[k] = cyc;
            n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL b2b_timeout[%0d]: got %b expected 1", k, ok); end
            n_cmp++; if (out_bcd !== vexp[k]) begin n_bad++; $display("FAIL b2b_bcd[%0d]: got %h expected %h", k, out_bcd, vexp[k]); end
            $display("back_to_back: in=%0d bcd=%h cycle=%0d", vin[k], out_bcd, t[k]);
        end
        in_valid = 1'b0;
        for (int k = 1; k < 4; k++) begin
            n_cmp++; if (t[k] - t[k-1] != 22) begin n_bad++; $display("FAIL b2b_spacing[%0d]: got %0d expected 22", k, t[k] - t[k-1]); end
        end
        step();
    endtask

    initial begin
        test_reset();
        test_zero();
        test_values();
        test_overflow();
        test_backpressure();
        test_reset_mid_shift();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
